registrador_universal: RTL and testbench



---
 rtl/registrador_universal.sv | 137 +++++++++++++
 tb/tb_registrador_universal.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/registrador_universal.sv
// registrador_universal
//
// Universal register for the SAP-1 datapath. Holds a DATA_SIZE-bit word and,
// on each rising CK edge, either holds, loads in parallel, shifts, rotates or
// (optionally) increments/decrements it. A registered CARRY bit captures the
// shifted-out bit, the increment carry or the decrement borrow. ZERO is a
// combinational decode of the stored word.
//
// Optional feature macro: REGISTRADOR_UNIVERSAL_ARITH_EN
//   defined     -> MODE 110 increments, MODE 111 decrements
//   not defined -> MODE 110/111 hold, and no adder is built
//
// Ports:
//   CK        in   clock, rising edge
//   MR        in   asynchronous active-high reset (clears word and CARRY)
//   EN        in   operation enable; low holds regardless of MODE
//   CLR       in   synchronous clear; wins over EN and MODE
//   MODE[2:0] in   000 hold, 001 load, 010 shl, 011 shr,
//                  100 rol, 101 ror, 110 inc, 111 dec
//   SER_IN    in   fill bit for the shift modes
//   DATA_IN   in   parallel load word
//   DATA_OUT  out  registered word
//   CARRY     out  registered shift-out / carry / borrow
//   ZERO      out  high when DATA_OUT == 0
//
// There is no handshake: every enabled edge performs one operation, so EN may
// stay high for back-to-back operations.

module registrador_universal #(
  parameter int DATA_SIZE = 8
) (
  input  logic                 CK,
  input  logic                 MR,
  input  logic                 EN,
  input  logic                 CLR,
  input  logic [2:0]           MODE,
  input  logic                 SER_IN,
  input  logic [DATA_SIZE-1:0] DATA_IN,
  output logic [DATA_SIZE-1:0] DATA_OUT,
  output logic                 CARRY,
  output logic                 ZERO
);

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_LOAD = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_SHR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_INC  = 3'b110;
  localparam logic [2:0] MODE_DEC  = 3'b111;

  logic [DATA_SIZE-1:0] data_q, data_d;
  logic                 carry_q, carry_d;

`ifdef REGISTRADOR_UNIVERSAL_ARITH_EN
  // One bit wider than the word so the top bit is the carry (increment) or
  // the borrow (decrement: 0 - 1 sets every bit, including the extra one).
  localparam logic [DATA_SIZE:0] ONE_EXT = {{DATA_SIZE{1'b0}}, 1'b1};
  logic [DATA_SIZE:0] inc_sum;
  logic [DATA_SIZE:0] dec_diff;

  assign inc_sum  = {1'b0, data_q} + ONE_EXT;
  assign dec_diff = {1'b0, data_q} - ONE_EXT;
`endif

  always_comb begin
    data_d  = data_q;
    carry_d = carry_q;
    if (CLR) begin
      data_d  = '0;
      carry_d = 1'b0;
    end else if (EN) begin
      case (MODE)
        MODE_HOLD: begin
          data_d  = data_q;
          carry_d = carry_q;
        end
        MODE_LOAD: begin
          data_d  = DATA_IN;
          carry_d = 1'b0;
        end
        MODE_SHL: begin
          data_d  = {data_q[DATA_SIZE-2:0], SER_IN};
          carry_d = data_q[DATA_SIZE-1];
        end
        MODE_SHR: begin
          data_d  = {SER_IN, data_q[DATA_SIZE-1:1]};
          carry_d = data_q[0];
        end
        MODE_ROL: begin
          data_d  = {data_q[DATA_SIZE-2:0], data_q[DATA_SIZE-1]};
          carry_d = data_q[DATA_SIZE-1];
        end
        MODE_ROR: begin
          data_d  = {data_q[0], data_q[DATA_SIZE-1:1]};
          carry_d = data_q[0];
        end
`ifdef REGISTRADOR_UNIVERSAL_ARITH_EN
        MODE_INC: begin
          data_d  = inc_sum[DATA_SIZE-1:0];
          carry_d = inc_sum[DATA_SIZE];
        end
        MODE_DEC: begin
          data_d  = dec_diff[DATA_SIZE-1:0];
          carry_d = dec_diff[DATA_SIZE];
        end
`else
        // Without the arithmetic option these codes simply hold.
        MODE_INC, MODE_DEC: begin
          data_d  = data_q;
          carry_d = carry_q;
        end
`endif
        default: begin
          data_d  = data_q;
          carry_d = carry_q;
        end
      endcase
    end
  end

  always_ff @(posedge CK or posedge MR) begin
    if (MR) begin
      data_q  <= '0;
      carry_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      carry_q <= carry_d;
    end
  end

  assign DATA_OUT = data_q;
  assign CARRY    = carry_q;
  assign ZERO     = (data_q == '0);

endmodule

// File: tb/tb_registrador_universal.sv
// Bench for registrador_universal: an 8-bit and a 4-bit instance share the
// control inputs. Directed steps push hand-computed {data, carry, zero}
// expectations into per-instance queues; a monitor pops and compares on the
// falling clock edge (or on an explicit sample event for the asynchronous
// reset check, which must be seen before any clock edge).

module tb_registrador_universal;

  logic       CK;
  logic       MR;
  logic       EN;
  logic       CLR;
  logic [2:0] MODE;
  logic       SER_IN;
  logic [7:0] din8;
  logic [3:0] din4;
  logic [7:0] dout8;
  logic [3:0] dout4;
  logic       carry8, carry4, zero8, zero4;

  int n_checks = 0;
  int n_pass   = 0;

  logic [9:0] exp8_q[$];   // {data[7:0], carry, zero}
  logic [5:0] exp4_q[$];   // {data[3:0], carry, zero}
  event       sample_ev;

  registrador_universal #(.DATA_SIZE(8)) dut8 (
    .CK(CK), .MR(MR), .EN(EN), .CLR(CLR), .MODE(MODE), .SER_IN(SER_IN),
    .DATA_IN(din8), .DATA_OUT(dout8), .CARRY(carry8), .ZERO(zero8)
  );

  registrador_universal #(.DATA_SIZE(4)) dut4 (
    .CK(CK), .MR(MR), .EN(EN), .CLR(CLR), .MODE(MODE), .SER_IN(SER_IN),
    .DATA_IN(din4), .DATA_OUT(dout4), .CARRY(carry4), .ZERO(zero4)
  );

  // ---------------- clock / reset ----------------
  initial CK = 1'b0;
  always #5 CK = ~CK;

  // ---------------- monitor / scoreboard ----------------
  always begin
    logic [9:0] e8;
    logic [5:0] e4;
    @(negedge CK or sample_ev);
    if (exp8_q.size() > 0) begin
      e8 = exp8_q.pop_front();
      n_checks++;
      if ({dout8, carry8, zero8} === e8) n_pass++;
      else $display("FAIL w8: data=%h carry=%b zero=%b expected data=%h carry=%b zero=%b",
                    dout8, carry8, zero8, e8[9:2], e8[1], e8[0]);
    end
    if (exp4_q.size() > 0) begin
      e4 = exp4_q.pop_front();
      n_checks++;
      if ({dout4, carry4, zero4} === e4) n_pass++;
      else $display("FAIL w4: data=%h carry=%b zero=%b expected data=%h carry=%b zero=%b",
                    dout4, carry4, zero4, e4[5:2], e4[1], e4[0]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic clr, input logic en, input logic [2:0] mode,
                       input logic ser, input logic [7:0] d8, input logic [3:0] d4);
    @(negedge CK);
    CLR = clr; EN = en; MODE = mode; SER_IN = ser; din8 = d8; din4 = d4;
    @(posedge CK);
  endtask

  task automatic step8(input logic clr, input logic en, input logic [2:0] mode,
                       input logic ser, input logic [7:0] d8,
                       input logic [7:0] ed, input logic ec);
    drive(clr, en, mode, ser, d8, 4'h0);
    exp8_q.push_back({ed, ec, (ed == 8'h00)});
  endtask

  task automatic step4(input logic clr, input logic en, input logic [2:0] mode,
                       input logic ser, input logic [3:0] d4,
                       input logic [3:0] ed, input logic ec);
    drive(clr, en, mode, ser, 8'h00, d4);
    exp4_q.push_back({ed, ec, (ed == 4'h0)});
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL timeout: sim time exceeded, expected bench to complete");
    n_checks++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] v;
    logic       c;
    MR = 1'b1; EN = 1'b0; CLR = 1'b0; MODE = 3'b000; SER_IN = 1'b0;
    din8 = 8'h00; din4 = 4'h0;
    repeat (2) @(posedge CK);
    // Reset values.
    #1;
    exp8_q.push_back({8'h00, 1'b0, 1'b1});
    exp4_q.push_back({4'h0, 1'b0, 1'b1});
    -> sample_ev;
    @(negedge CK);
    MR = 1'b0;

    // Load, then MR asserted mid-load clears without a clock edge.
    step8(0, 1, 3'b001, 0, 8'h5A, 8'h5A, 0);
    @(negedge CK);
    EN = 1'b1; MODE = 3'b001; din8 = 8'hA5;
    #2 MR = 1'b1;
    #1;
    exp8_q.push_back({8'h00, 1'b0, 1'b1});
    -> sample_ev;
    @(negedge CK);
    MR = 1'b0;
    step8(0, 1, 3'b001, 0, 8'hA5, 8'hA5, 0);

    // Shifts.
    step8(0, 1, 3'b001, 0, 8'h81, 8'h81, 0);
    step8(0, 1, 3'b010, 0, 8'h00, 8'h02, 1);
    step8(0, 1, 3'b011, 1, 8'h00, 8'h81, 0);

    // Rotates.
    step8(0, 1, 3'b001, 0, 8'h01, 8'h01, 0);
    step8(0, 1, 3'b101, 0, 8'h00, 8'h80, 1);
    step8(0, 1, 3'b100, 0, 8'h00, 8'h01, 1);
    for (int i = 0; i < 8; i++)
      step8(0, 1, 3'b100, 0, 8'h00, 8'(8'h01 << ((i + 1) % 8)), (i == 7));

    // Arithmetic.
    step8(0, 1, 3'b001, 0, 8'hFF, 8'hFF, 0);
`ifdef REGISTRADOR_UNIVERSAL_ARITH_EN
    step8(0, 1, 3'b110, 0, 8'h00, 8'h00, 1);
    step8(0, 1, 3'b111, 0, 8'h00, 8'hFF, 1);
    step8(0, 1, 3'b111, 0, 8'h00, 8'hFE, 0);
    step8(0, 1, 3'b110, 0, 8'h00, 8'hFF, 0);
`else
    step8(0, 1, 3'b110, 0, 8'h00, 8'hFF, 0);
    step8(0, 1, 3'b111, 0, 8'h00, 8'hFF, 0);
    step8(0, 1, 3'b111, 0, 8'h00, 8'hFF, 0);
    step8(0, 1, 3'b110, 0, 8'h00, 8'hFF, 0);
`endif

    // Priority: CLR over EN/MODE; EN low holds word and CARRY.
    step8(0, 1, 3'b001, 0, 8'h3C, 8'h3C, 0);
    step8(1, 1, 3'b001, 0, 8'h55, 8'h00, 0);
    step8(0, 1, 3'b001, 0, 8'h3C, 8'h3C, 0);
    step8(0, 0, 3'b010, 1, 8'h00, 8'h3C, 0);
    step8(0, 1, 3'b001, 0, 8'h81, 8'h81, 0);
    step8(0, 1, 3'b010, 0, 8'h00, 8'h02, 1);
    step8(0, 0, 3'b011, 1, 8'h77, 8'h02, 1);
    step8(0, 1, 3'b000, 1, 8'h77, 8'h02, 1);
    step8(1, 0, 3'b001, 0, 8'h77, 8'h00, 0);

    // Serialise 0xA5 through CARRY, MSB first.
    step8(0, 1, 3'b001, 0, 8'hA5, 8'hA5, 0);
    v = 8'hA5;
    for (int i = 0; i < 8; i++) begin
      c = v[7];
      v = {v[6:0], 1'b0};
      step8(0, 1, 3'b010, 0, 8'h00, v, c);
    end

    // Width 4.
    step4(0, 1, 3'b001, 0, 4'hF, 4'hF, 0);
`ifdef REGISTRADOR_UNIVERSAL_ARITH_EN
    step4(0, 1, 3'b110, 0, 4'h0, 4'h0, 1);
    step4(0, 1, 3'b111, 0, 4'h0, 4'hF, 1);
`else
    step4(0, 1, 3'b110, 0, 4'h0, 4'hF, 0);
    step4(0, 1, 3'b111, 0, 4'h0, 4'hF, 0);
`endif
    step4(0, 1, 3'b001, 0, 4'h8, 4'h8, 0);
    step4(0, 1, 3'b010, 1, 4'h0, 4'h1, 1);
    step4(0, 1, 3'b011, 1, 4'h0, 4'h8, 1);
    step4(0, 1, 3'b101, 0, 4'h0, 4'h4, 0);

    // Drain the scoreboard, bounded.
    for (int i = 0; i < 4 && (exp8_q.size() > 0 || exp4_q.size() > 0); i++)
      @(negedge CK);
    #1;
    if (exp8_q.size() > 0 || exp4_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d/%0d entries left, expected 0/0",
               exp8_q.size(), exp4_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
